// File: rtl/dma_rr_descriptor_requester.sv
// dma_rr_descriptor_requester: round-robin requester for one priority level of the DMA arbiter.
// Rev 1.0 - initial release.
`default_nettype none

module dma_rr_descriptor_requester #(
  parameter int NUM_OF_BDS       = 4,
  parameter int NUM_OF_BDS_WIDTH = 2,
  parameter int STREAM_EN        = 0
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NUM_OF_BDS-1:0]       dscrptrReq,
  input  logic                        strDscrptrReq,
  input  logic                        reqEn,
  output logic                        req,
  output logic [NUM_OF_BDS_WIDTH-1:0] intDscrptrNum,
  output logic                        strDscrptr,
  output logic [NUM_OF_BDS-1:0]       grantDscrptr
);

  localparam int NUM_SLOTS = NUM_OF_BDS + STREAM_EN;
  localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t               state;
  logic [NUM_SLOTS-1:0] slots;
  logic [NUM_SLOTS-1:0] mask;
  logic [NUM_SLOTS-1:0] masked;
  logic [NUM_SLOTS-1:0] win_oh;
  logic [NUM_SLOTS-1:0] next_mask;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     win_q;
  logic                 win_is_stream;
  logic                 win_live;

  generate
    if (STREAM_EN != 0) begin : g_stream
      assign slots = {strDscrptrReq, dscrptrReq};
    end else begin : g_no_stream
      logic unused_str;
      assign unused_str = strDscrptrReq;
      assign slots      = dscrptrReq;
    end
  endgenerate

  // Lowest set bit of the masked slots wins; fall back to the unmasked slots once the mask is exhausted.
  always_comb begin
    masked  = slots & mask;
    win_idx = '0;
    if (masked != '0) begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (masked[i]) win_idx = IDX_W'(i);
      end
    end else begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (slots[i]) win_idx = IDX_W'(i);
      end
    end
    win_is_stream = (STREAM_EN != 0) && (int'(win_idx) == NUM_OF_BDS);
  end

  // Decode of the presented winner: grant pulse source, withdrawal check and post-grant mask.
  always_comb begin
    win_oh    = '0;
    next_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      win_oh[i]    = (int'(win_q) == i);
      next_mask[i] = (i > int'(win_q));
    end
    if (int'(win_q) == NUM_SLOTS - 1) next_mask = '1;
    win_live = |(slots & win_oh);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      mask          <= '1;
      win_q         <= '0;
      req           <= 1'b0;
      intDscrptrNum <= '0;
      strDscrptr    <= 1'b0;
      grantDscrptr  <= '0;
    end else begin
      grantDscrptr <= '0;
      case (state)
        IDLE: begin
          if (slots != '0) begin
            win_q <= win_idx;
            req   <= 1'b1;
            if (win_is_stream) begin
              intDscrptrNum <= '0;
              strDscrptr    <= 1'b1;
            end else begin
              intDscrptrNum <= NUM_OF_BDS_WIDTH'(win_idx);
              strDscrptr    <= 1'b0;
            end
            state <= PRESENT;
          end
        end
        PRESENT: begin
          // A grant wins over a simultaneous withdrawal.
          if (reqEn) begin
            mask         <= next_mask;
            req          <= 1'b0;
            grantDscrptr <= win_oh[NUM_OF_BDS-1:0];
            state        <= HOLD;
          end else if (!win_live) begin
            req   <= 1'b0;
            state <= IDLE;
          end
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_rr_descriptor_requester.sv
// Directed self-checking bench for dma_rr_descriptor_requester (plain and stream-enabled instances).
`default_nettype none

module tb_dma_rr_descriptor_requester;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] dscrptrReq;
  logic       strDscrptrReq;
  logic       reqEn;
  logic       req;
  logic [1:0] intDscrptrNum;
  logic       strDscrptr;
  logic [3:0] grantDscrptr;

  logic [3:0] dr2;
  logic       sr2;
  logic       en2;
  logic       req2;
  logic [1:0] num2;
  logic       str2;
  logic [3:0] grant2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dma_rr_descriptor_requester #(
    .NUM_OF_BDS(4), .NUM_OF_BDS_WIDTH(2), .STREAM_EN(0)
  ) dut (
    .clock(clock), .resetn(resetn), .dscrptrReq(dscrptrReq), .strDscrptrReq(strDscrptrReq),
    .reqEn(reqEn), .req(req), .intDscrptrNum(intDscrptrNum), .strDscrptr(strDscrptr),
    .grantDscrptr(grantDscrptr)
  );

  dma_rr_descriptor_requester #(
    .NUM_OF_BDS(4), .NUM_OF_BDS_WIDTH(2), .STREAM_EN(1)
  ) dut_str (
    .clock(clock), .resetn(resetn), .dscrptrReq(dr2), .strDscrptrReq(sr2),
    .reqEn(en2), .req(req2), .intDscrptrNum(num2), .strDscrptr(str2),
    .grantDscrptr(grant2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Grant the presented winner, then apply next_req and expect the next presentation after two low cycles.
  task automatic grant_cycle(input logic [3:0] exp_g, input logic [3:0] next_req, input logic [1:0] exp_num);
    reqEn = 1'b1;
    step;
    chk("grant_req_low", 32'(req), 32'd0);
    chk("grant_pulse", 32'(grantDscrptr), 32'(exp_g));
    reqEn      = 1'b0;
    dscrptrReq = next_req;
    step;
    chk("hold_req_low", 32'(req), 32'd0);
    chk("hold_grant_clr", 32'(grantDscrptr), 32'd0);
    step;
    chk("next_req", 32'(req), 32'd1);
    chk("next_num", 32'(intDscrptrNum), 32'(exp_num));
  endtask

  initial begin
    resetn        = 1'b0;
    reqEn         = 1'b0;
    dscrptrReq    = 4'b1111;
    strDscrptrReq = 1'b0;
    dr2           = 4'b0000;
    sr2           = 1'b0;
    en2           = 1'b0;

    repeat (3) step;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_num", 32'(intDscrptrNum), 32'd0);
    chk("rst_str", 32'(strDscrptr), 32'd0);
    chk("rst_grant", 32'(grantDscrptr), 32'd0);
    resetn = 1'b1;
    #1;
    chk("post_rst_req", 32'(req), 32'd0);
    step;
    chk("first_req", 32'(req), 32'd1);
    chk("first_num", 32'(intDscrptrNum), 32'd0);

    // Full rotation with all four pending; granting slot 3 wraps back to 0.
    grant_cycle(4'b0001, 4'b1111, 2'd1);
    grant_cycle(4'b0010, 4'b1111, 2'd2);
    grant_cycle(4'b0100, 4'b1111, 2'd3);
    grant_cycle(4'b1000, 4'b1111, 2'd0);

    // Withdraw the presented slot 0, re-arbitrate among 1010.
    dscrptrReq = 4'b1010;
    step;
    chk("withdraw_req_low", 32'(req), 32'd0);
    step;
    chk("rearb_req", 32'(req), 32'd1);
    chk("rearb_num", 32'(intDscrptrNum), 32'd1);

    // Presented winner stays frozen when other bits change.
    dscrptrReq = 4'b1011;
    step;
    chk("frozen_req", 32'(req), 32'd1);
    chk("frozen_num", 32'(intDscrptrNum), 32'd1);
    dscrptrReq = 4'b1010;

    grant_cycle(4'b0010, 4'b1010, 2'd3);
    grant_cycle(4'b1000, 4'b1010, 2'd1);
    grant_cycle(4'b0010, 4'b1010, 2'd3);
    grant_cycle(4'b1000, 4'b1010, 2'd1);

    // Present 2, then withdraw it without a grant.
    dscrptrReq = 4'b1100;
    step;
    chk("w2_drop_req", 32'(req), 32'd0);
    step;
    chk("w2_req", 32'(req), 32'd1);
    chk("w2_num", 32'(intDscrptrNum), 32'd2);
    dscrptrReq = 4'b1000;
    step;
    chk("w2_withdraw_req", 32'(req), 32'd0);
    step;
    chk("w3_req", 32'(req), 32'd1);
    chk("w3_num", 32'(intDscrptrNum), 32'd3);
    grant_cycle(4'b1000, 4'b1100, 2'd2);

    // Withdrawal coincident with the grant: grant of 2 stands.
    dscrptrReq = 4'b1000;
    grant_cycle(4'b0100, 4'b1000, 2'd3);

    // reqEn held through HOLD and an empty IDLE must do nothing.
    reqEn = 1'b1;
    step;
    chk("g3_pulse", 32'(grantDscrptr), 32'b1000);
    dscrptrReq = 4'b0000;
    step;
    chk("hold_en_req", 32'(req), 32'd0);
    chk("hold_en_grant", 32'(grantDscrptr), 32'd0);
    step;
    chk("idle_en_req", 32'(req), 32'd0);
    chk("idle_en_grant", 32'(grantDscrptr), 32'd0);
    step;
    chk("idle_en_grant2", 32'(grantDscrptr), 32'd0);
    reqEn      = 1'b0;
    dscrptrReq = 4'b1010;
    step;
    chk("after_idle_req", 32'(req), 32'd1);
    chk("after_idle_num", 32'(intDscrptrNum), 32'd1);

    // Asynchronous reset while presenting.
    resetn = 1'b0;
    #1;
    chk("async_rst_req", 32'(req), 32'd0);
    chk("async_rst_num", 32'(intDscrptrNum), 32'd0);
    step;
    resetn     = 1'b1;
    dscrptrReq = 4'b0000;
    step;
    chk("after_async_req", 32'(req), 32'd0);

    // Stream-enabled instance: 0, stream, 0.
    dr2 = 4'b0001;
    sr2 = 1'b1;
    step;
    chk("s1_req", 32'(req2), 32'd1);
    chk("s1_num", 32'(num2), 32'd0);
    chk("s1_str", 32'(str2), 32'd0);
    en2 = 1'b1;
    step;
    chk("s1_req_low", 32'(req2), 32'd0);
    chk("s1_grant", 32'(grant2), 32'b0001);
    en2 = 1'b0;
    step;
    step;
    chk("s2_req", 32'(req2), 32'd1);
    chk("s2_num", 32'(num2), 32'd0);
    chk("s2_str", 32'(str2), 32'd1);
    en2 = 1'b1;
    step;
    chk("s2_req_low", 32'(req2), 32'd0);
    chk("s2_grant", 32'(grant2), 32'd0);
    en2 = 1'b0;
    step;
    step;
    chk("s3_req", 32'(req2), 32'd1);
    chk("s3_num", 32'(num2), 32'd0);
    chk("s3_str", 32'(str2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
